// File: rtl/fir_mac_sched_pkg.sv
// Shared widths, FSM state type and datapath typedefs for the sequential FIR engine.
package FirPkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned TAPS       = 8;
    localparam int unsigned ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(TAPS);

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StDone
    } fir_state_e;

    typedef logic [DATA_WIDTH-1:0] sample_t;
    typedef logic [ACC_WIDTH-1:0]  acc_t;

endpackage

// File: rtl/fir_mac_sched_mul_nbit.sv
// Unsigned W x W combinational multiplier producing a full 2W-bit product.
module mul_nbit #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    output logic [2*W-1:0] P
);

    // Operands widened first so the product is never truncated.
    assign P = {{W{1'b0}}, A} * {{W{1'b0}}, B};

endmodule

// File: rtl/fir_mac_sched.sv
// Sequential FIR engine: one shared multiplier, one multiply-accumulate per cycle,
// valid/ready on both the sample input and the result output.
module fir_mac_sched #(
    parameter int unsigned DATA_WIDTH = FirPkg::DATA_WIDTH,
    parameter int unsigned TAPS       = 8,
    parameter int unsigned ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(TAPS)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      coef_we_i,
    input  logic [$clog2(TAPS)-1:0]   coef_addr_i,
    input  logic [DATA_WIDTH-1:0]     coef_data_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [DATA_WIDTH-1:0]     in_data_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [ACC_WIDTH-1:0]      out_data_o,
    output logic                      busy_o
);

    import FirPkg::*;

    localparam int unsigned TapW = $clog2(TAPS);

    fir_state_e              state_q, state_d;
    logic [TapW-1:0]         tap_q, tap_d;
    logic [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic [ACC_WIDTH-1:0]    out_q, out_d;
    logic [DATA_WIDTH-1:0]   x_q [TAPS];
    logic [DATA_WIDTH-1:0]   x_d [TAPS];
    logic [DATA_WIDTH-1:0]   c_q [TAPS];
    logic [DATA_WIDTH-1:0]   c_d [TAPS];
    logic [2*DATA_WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0]    prod_ext;
    logic [ACC_WIDTH-1:0]    acc_sum;
    logic                    accept;
    logic                    last_tap;

    assign accept   = in_valid_i && (state_q == StIdle);
    assign last_tap = (tap_q == TapW'(TAPS - 1));
    assign prod_ext = ACC_WIDTH'(prod);
    assign acc_sum  = acc_q + prod_ext;

    mul_nbit #(
        .W (DATA_WIDTH)
    ) u_mul (
        .A (x_q[tap_q]),
        .B (c_q[tap_q]),
        .P (prod)
    );

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept)      state_d = StMac;
            StMac:   if (last_tap)    state_d = StDone;
            StDone:  if (out_ready_i) state_d = StIdle;
            default:                  state_d = StIdle;
        endcase
    end

    // FSM outputs: pure decodes of the state register.
    always_comb begin
        in_ready_o  = (state_q == StIdle);
        out_valid_o = (state_q == StDone);
        busy_o      = (state_q != StIdle);
    end

    // Datapath next state: coefficient writes, delay-line shift, accumulation.
    always_comb begin
        x_d   = x_q;
        c_d   = c_q;
        acc_d = acc_q;
        tap_d = tap_q;
        out_d = out_q;
        // Write lands at the same edge as a handshake, so the new sample sees it.
        if (coef_we_i && (state_q == StIdle)) begin
            c_d[coef_addr_i] = coef_data_i;
        end
        if (accept) begin
            x_d[0] = in_data_i;
            for (int unsigned k = 1; k < TAPS; k++) begin
                x_d[k] = x_q[k-1];
            end
            acc_d = '0;
            tap_d = '0;
        end
        if (state_q == StMac) begin
            acc_d = acc_sum;
            tap_d = tap_q + 1'b1;
            if (last_tap) begin
                out_d = acc_sum;
                tap_d = '0;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tap_q <= '0;
            acc_q <= '0;
            out_q <= '0;
            for (int unsigned k = 0; k < TAPS; k++) begin
                x_q[k] <= '0;
                c_q[k] <= '0;
            end
        end else begin
            tap_q <= tap_d;
            acc_q <= acc_d;
            out_q <= out_d;
            x_q   <= x_d;
            c_q   <= c_d;
        end
    end

    assign out_data_o = out_q;

endmodule
